axis_fifo_m_axis_unpacker: RTL and testbench

//  Downstream stage of the S_AXIS byte-packer + axis_fifo_connection pair.

---
 rtl/axis_fifo_m_axis_unpacker_if.sv | 22 ++
 rtl/axis_fifo_m_axis_unpacker.sv | 82 ++++++++
 tb/tb_axis_fifo_m_axis_unpacker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_fifo_m_axis_unpacker_if.sv
// axis_fifo_m_axis_unpacker_if: FIFO read port plus AXI4-Stream master signals of the unpacker
interface axis_fifo_m_axis_unpacker_if #(
  parameter int C_M_AXIS_TDATA_WIDTH = 24,
  parameter int FIFO_DATA_WIDTH      = 32
);
  logic                                empty;
  logic                                pop_en;
  logic [FIFO_DATA_WIDTH-1:0]          output_data;
  logic                                M_AXIS_TVALID;
  logic                                M_AXIS_TREADY;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP;
  logic                                M_AXIS_TLAST;
  modport master (
    input  empty, output_data, M_AXIS_TREADY,
    output pop_en, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST
  );
  modport slave (
    output empty, output_data, M_AXIS_TREADY,
    input  pop_en, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST
  );
endinterface

// File: rtl/axis_fifo_m_axis_unpacker.sv
// axis_fifo_m_axis_unpacker: pops packed FIFO words and replays them as an AXI4-Stream master.
// Optional M_AXIS_PKT_CNT_EN adds a 16-bit completed-packet counter port pkt_count.
module axis_fifo_m_axis_unpacker #(
  parameter int C_M_AXIS_TDATA_WIDTH = 24,
  parameter int FIFO_DATA_WIDTH      = 32,
  parameter int CW                   = 2
) (
  input  logic M_AXIS_ACLK,
  input  logic M_AXIS_ARESET,
`ifdef M_AXIS_PKT_CNT_EN
  output logic [15:0] pkt_count,
`endif
  axis_fifo_m_axis_unpacker_if.master bus
);
  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int NB = DW / 8;
  logic          out_v_q, out_v_d, skid_v_q, skid_v_d, rd_q;
  logic [DW-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [NB-1:0] out_keep_q, out_keep_d, skid_keep_q, skid_keep_d, ret_keep;
  logic          out_last_q, out_last_d, skid_last_q, skid_last_d;
  logic          beat, ret_to_out, ret_to_skid, sat, unused_bits;
  logic [CW-1:0] n;
  logic [1:0]    occ;
  assign beat        = out_v_q & bus.M_AXIS_TREADY;
  assign occ         = 2'(out_v_q) + 2'(skid_v_q) + 2'(rd_q) - 2'(beat);
  assign bus.pop_en  = !M_AXIS_ARESET && !bus.empty && occ < 2'd2;
  assign ret_to_out  = rd_q && (!out_v_q || beat);
  assign ret_to_skid = rd_q && out_v_q && !beat;
  assign n           = bus.output_data[DW +: CW];
  assign sat         = n == '0 || n > CW'(NB);
  assign unused_bits = ^bus.output_data;
  for (genvar i = 0; i < NB; i++) begin : g_keep
    assign ret_keep[i] = sat | (CW'(i) < n);
  end
  // A returning read has priority into OUT; otherwise a drained OUT refills from SKID.
  always_comb begin
    out_v_d     = ret_to_out ? 1'b1 : beat ? skid_v_q : out_v_q;
    out_data_d  = ret_to_out ? bus.output_data[DW-1:0] : beat ? skid_data_q : out_data_q;
    out_keep_d  = ret_to_out ? ret_keep : beat ? skid_keep_q : out_keep_q;
    out_last_d  = ret_to_out ? bus.output_data[FIFO_DATA_WIDTH-1] : beat ? skid_last_q : out_last_q;
    skid_v_d    = ret_to_skid ? 1'b1 : beat ? 1'b0 : skid_v_q;
    skid_data_d = ret_to_skid ? bus.output_data[DW-1:0] : skid_data_q;
    skid_keep_d = ret_to_skid ? ret_keep : skid_keep_q;
    skid_last_d = ret_to_skid ? bus.output_data[FIFO_DATA_WIDTH-1] : skid_last_q;
  end
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_keep_q <= '0;
      skid_last_q <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_keep_q <= skid_keep_d;
      skid_last_q <= skid_last_d;
      rd_q        <= bus.pop_en;
    end
  end
  assign bus.M_AXIS_TVALID = out_v_q;
  assign bus.M_AXIS_TDATA  = out_data_q;
  assign bus.M_AXIS_TKEEP  = out_keep_q;
  assign bus.M_AXIS_TLAST  = out_last_q;
`ifdef M_AXIS_PKT_CNT_EN
  logic [15:0] pkt_q, pkt_d;
  assign pkt_d = pkt_q + 16'(beat & out_last_q);
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) pkt_q <= '0;
    else pkt_q <= pkt_d;
  end
  assign pkt_count = pkt_q;
`endif
endmodule

// File: tb/tb_axis_fifo_m_axis_unpacker.sv
// tb_axis_fifo_m_axis_unpacker: directed bench with a behavioural FIFO and an in-order beat scoreboard.
module tb_axis_fifo_m_axis_unpacker;
  localparam int DW = 24;
  localparam int FW = 32;
  localparam int CW = 2;
  typedef struct {
    logic [CW-1:0] n;
    logic [23:0]   d;
    logic          l;
    logic [2:0]    ek;
    logic [23:0]   ed;
    logic          el;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  axis_fifo_m_axis_unpacker_if #(.C_M_AXIS_TDATA_WIDTH(DW), .FIFO_DATA_WIDTH(FW)) bus ();
`ifdef M_AXIS_PKT_CNT_EN
  logic [15:0] pkt_count;
`endif
  axis_fifo_m_axis_unpacker #(.C_M_AXIS_TDATA_WIDTH(DW), .FIFO_DATA_WIDTH(FW), .CW(CW)) dut (
    .M_AXIS_ACLK  (clk),
    .M_AXIS_ARESET(rst),
`ifdef M_AXIS_PKT_CNT_EN
    .pkt_count    (pkt_count),
`endif
    .bus          (bus)
  );
  always #5 clk = ~clk;
  logic [FW-1:0] mem [256];
  logic [23:0]   exp_d [256];
  logic [CW-1:0] exp_n [256];
  logic          exp_l [256];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int rx_idx   = 0;
  logic [FW-1:0] rdata = '0;
  assign bus.empty       = (push_cnt == pop_cnt);
  assign bus.output_data = rdata;
  // FIFO model: one-cycle read latency, cleared by the shared reset
  always @(posedge clk) begin
    if (rst) pop_cnt <= push_cnt;
    else if (bus.pop_en) begin
      rdata   <= mem[pop_cnt % 256];
      pop_cnt <= pop_cnt + 1;
    end
  end
  function automatic logic [2:0] keep_of(input logic [CW-1:0] n);
    case (n)
      2'd1:    keep_of = 3'b001;
      2'd2:    keep_of = 3'b011;
      default: keep_of = 3'b111;
    endcase
  endfunction
  int mon_checks = 0;
  int mon_errors = 0;
  logic prev_stall = 1'b0;
  logic [27:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      rx_idx     = push_cnt;
      prev_stall = 1'b0;
    end else begin
      mon_checks++;
      if (bus.pop_en && bus.empty) begin
        mon_errors++;
        $display("FAIL pop_while_empty: pop_en=1 empty=1 at %0t", $time);
      end
      if (prev_stall) begin
        mon_checks++;
        if ({bus.M_AXIS_TVALID, bus.M_AXIS_TDATA, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST} !== {1'b1, held}) begin
          mon_errors++;
          $display("FAIL stall_stable: got v=%b %h required v=1 %h", bus.M_AXIS_TVALID,
                   {bus.M_AXIS_TDATA, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST}, held);
        end
      end
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
        mon_checks++;
        if (rx_idx >= push_cnt) begin
          mon_errors++;
          $display("FAIL extra_beat: got beat %h required none", bus.M_AXIS_TDATA);
        end else if ({bus.M_AXIS_TDATA, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST} !==
                     {exp_d[rx_idx % 256], keep_of(exp_n[rx_idx % 256]), exp_l[rx_idx % 256]}) begin
          mon_errors++;
          $display("FAIL beat_%0d: got %h/%b/%b required %h/%b/%b", rx_idx, bus.M_AXIS_TDATA,
                   bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST, exp_d[rx_idx % 256],
                   keep_of(exp_n[rx_idx % 256]), exp_l[rx_idx % 256]);
        end
        rx_idx++;
      end
      prev_stall = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
      held       = {bus.M_AXIS_TDATA, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST};
    end
  end
  int checks = 0;
  int errors = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask
  task automatic push(input logic [23:0] d, input logic [CW-1:0] n, input logic l);
    logic [FW-1:0] w;
    w = {l, 5'h15, n, d};
    mem[push_cnt % 256]   = w;
    exp_d[push_cnt % 256] = d;
    exp_n[push_cnt % 256] = n;
    exp_l[push_cnt % 256] = l;
    push_cnt++;
  endtask
  task automatic wait_drain(input string name, input int bound);
    int k;
    k = 0;
    while (rx_idx != push_cnt && k < bound) begin
      tick();
      k++;
    end
    chk(name, 32'(rx_idx), 32'(push_cnt));
  endtask
  vec_t vt [4];
  initial begin
    int pops;
    int k;
    int start;
    vt[0] = '{n: 2'd2, d: 24'h000201, l: 1'b1, ek: 3'b011, ed: 24'h000201, el: 1'b1};
    vt[1] = '{n: 2'd1, d: 24'hABCDEF, l: 1'b0, ek: 3'b001, ed: 24'hABCDEF, el: 1'b0};
    vt[2] = '{n: 2'd3, d: 24'h123456, l: 1'b1, ek: 3'b111, ed: 24'h123456, el: 1'b1};
    vt[3] = '{n: 2'd0, d: 24'hFFEE00, l: 1'b0, ek: 3'b111, ed: 24'hFFEE00, el: 1'b0};
    bus.M_AXIS_TREADY = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_state", {bus.pop_en, bus.M_AXIS_TVALID, bus.M_AXIS_TDATA, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST},
        '0);
    tick();
    // 1: sixteen full words queued at reset release
    for (int i = 0; i < 16; i++) push(24'h100000 + 24'(i * 3), 2'd3, i == 15);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_pop_same_cycle", {bus.pop_en, bus.M_AXIS_TVALID}, 2'b10);
    @(negedge clk);
    chk("t1_valid_lat1", bus.M_AXIS_TVALID, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("t1_b2b_%0d", i), {bus.M_AXIS_TVALID, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST},
          {1'b1, 3'b111, i == 15});
    end
    @(negedge clk);
    chk("t1_idle_after", bus.M_AXIS_TVALID, 1'b0);
    // 2: single-word decode vectors
    for (int v = 0; v < 4; v++) begin
      tick();
      push(vt[v].d, vt[v].n, vt[v].l);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.M_AXIS_TVALID && k < 10);
      chk($sformatf("t2_vec%0d", v), {bus.M_AXIS_TVALID, bus.M_AXIS_TDATA, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST},
          {1'b1, vt[v].ed, vt[v].ek, vt[v].el});
    end
    wait_drain("t2_drain", 10);
    // 3: long stall with eight words queued
    bus.M_AXIS_TREADY = 1'b0;
    start = push_cnt;
    for (int i = 0; i < 8; i++) push(24'h300000 + 24'(i), 2'(1 + i % 3), i == 7);
    pops = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.pop_en) pops++;
    end
    chk("t3_pops", 32'(pops), 32'd2);
    chk("t3_held", {bus.M_AXIS_TVALID, bus.M_AXIS_TDATA}, {1'b1, exp_d[start % 256]});
    tick();
    bus.M_AXIS_TREADY = 1'b1;
    wait_drain("t3_drain", 40);
    // 4: TREADY toggling every cycle
    for (int i = 0; i < 32; i++) push(24'(32'h00A5_0000 ^ (i * 32'h0001_0203)), 2'(i % 4), i % 8 == 7);
    k = 0;
    while (rx_idx != push_cnt && k < 200) begin
      tick();
      bus.M_AXIS_TREADY = ~bus.M_AXIS_TREADY;
      k++;
    end
    chk("t4_drain", 32'(rx_idx), 32'(push_cnt));
    bus.M_AXIS_TREADY = 1'b1;
    // 5: reset in the middle of a packet
    tick();
    start = rx_idx;
    for (int i = 0; i < 16; i++) push(24'h500000 + 24'(i), 2'd3, i == 15);
    k = 0;
    while (rx_idx - start < 4 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reached_mid", 32'(rx_idx - start >= 4), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_out", {bus.pop_en, bus.M_AXIS_TVALID, bus.M_AXIS_TDATA, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST},
        '0);
`ifdef M_AXIS_PKT_CNT_EN
    chk("t5_rst_pkt", 32'(pkt_count), 32'd0);
`endif
    tick();
    for (int i = 0; i < 4; i++) push(24'h5A0000 + 24'(i), 2'd3, i == 3);
    rst = 1'b0;
    wait_drain("t5_fresh_drain", 20);
`ifdef M_AXIS_PKT_CNT_EN
    // 6: packet counter and its wrap
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(24'h600000 + 24'(i), 2'd3, i == 3);
    push(24'h610000, 2'd1, 1'b1);
    for (int i = 0; i < 7; i++) push(24'h620000 + 24'(i), 2'd2, i == 6);
    wait_drain("t6_drain", 40);
    tick();
    chk("t6_pkt3", 32'(pkt_count), 32'd3);
    for (int i = 0; i < 65532; i++) begin
      while (push_cnt - rx_idx > 200) @(negedge clk);
      push(24'(i), 2'd3, 1'b1);
    end
    wait_drain("t6_bulk_drain", 400);
    tick();
    chk("t6_pkt_ffff", 32'(pkt_count), 32'h0000FFFF);
    push(24'h6FFFFF, 2'd3, 1'b1);
    wait_drain("t6_wrap_drain", 10);
    tick();
    chk("t6_pkt_wrap", 32'(pkt_count), 32'd0);
`endif
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks + mon_checks, errors + mon_errors);
    $finish;
  end
endmodule
